bin2bcd_seq: RTL and testbench
==============================

Name: bin2bcd_seq

Overview:
- Parametrised sequential binary-to-BCD converter using shift-add-3, one bit per clock.
- Generalises the team's fixed 16-bit/8-digit converter:
  - configurable input width and digit count;
  - valid/ready handshakes on input and output;
  - overflow detection;
  - back-to-back operation.
- Sits between arithmetic/counter datapaths and the seven-segment display drivers.

Parameters:
- BIN_W, 16: binary input width in bits, 2..32.
- DIGITS, 5: BCD output digits, 1..10. Output width is 4*DIGITS.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-low; when low at a rising edge, block resets.
- in_valid  input  1  in_bin holds a value to convert.
- in_ready  output  1  block can accept a value this cycle.
- in_bin  input  BIN_W  binary value; unsigned unless BIN2BCD_SIGNED_EN is defined.
- out_valid  output  1  out_bcd/out_ovf hold a finished result.
- out_ready  input  1  consumer accepts the result this cycle.
- out_bcd  output  4*DIGITS  packed BCD; digit 0 in [3:0].
- out_ovf  output  1  value did not fit in DIGITS digits.
- busy  output  1  conversion in progress (state SHIFT).
- out_neg  output  1  sign of result; present only with BIN2BCD_SIGNED_EN.

Behaviour:
- Reset values (rst low at an edge, any state):
  - state=IDLE, out_valid=0, out_bcd=0, out_ovf=0, out_neg=0, busy=0, bit counter=0.
  - Reset mid-conversion aborts it; no partial result is ever presented.
- States: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). It is combinational.
- Accept edge A: in_valid & in_ready high at edge A.
  - Capture in_bin into the binary shift register.
  - Clear the BCD register and the overflow sticky bit.
  - Load the counter with BIN_W.
  - Enter SHIFT.
- SHIFT, one step per edge:
  - Every digit of the BCD register that is >4 gets +3 (4-bit wrap-free, since max 12).
  - The {bcd, bin} concatenation shifts left by one.
  - The bit shifted out of the BCD MSB ORs into the overflow sticky bit.
  - The counter decrements.
- Completion:
  - The edge where the counter goes 1->0 performs the last step and enters DONE.
  - Result is visible, out_valid=1, after edge A+BIN_W.
  - Latency is therefore exactly BIN_W cycles from the accept edge.
- DONE:
  - out_bcd, out_ovf and out_neg are held stable while out_valid & ~out_ready (backpressure of any length).
  - On out_valid & out_ready: go to IDLE, unless in_valid is also high. In that case accept the new value in the same edge and enter SHIFT (out_valid drops).
  - Sustained throughput is one result per BIN_W+1 cycles.
- in_valid in SHIFT is ignored (in_ready=0); the source must hold it.
- Overflow:
  - out_ovf=1 iff the magnitude is >= 10^DIGITS.
  - out_bcd is then the magnitude mod 10^DIGITS, i.e. the low digits, still valid BCD.
- Counter width is $clog2(BIN_W+1).
- out_bcd is registered, taken directly from the BCD shift register. In DONE the register does not shift.
- Value 0: all digits 0, out_ovf=0, same latency.

Optional Feature:
- Macro BIN2BCD_SIGNED_EN.
- Defined:
  - in_bin is two's complement.
  - At the accept edge, the magnitude (|in_bin|, computed in BIN_W bits) is captured and the sign goes to out_neg.
  - -2^(BIN_W-1) converts correctly as magnitude 2^(BIN_W-1).
  - out_neg is held with the result and cleared by reset.
  - Latency is unchanged.
- Not defined:
  - Port out_neg is absent.
  - in_bin is unsigned.
  - No negation logic is synthesised.

Decomposition:
- Package bin2bcd_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2;
  - constant BCD_ADJ_THRESH=4'd4 and BCD_ADJ_ADD=4'd3.
- Sub-module bcd_digit_adj: combinational 4-bit in -> 4-bit out, +3 when >4. It is instantiated DIGITS times via generate.
- FSM, counter and shift registers stay in bin2bcd_seq.

Test Plan:
- Default params, in_bin=16'hFFFF, out_ready=1 -> out_valid rises 16 cycles after accept; out_bcd=20'h65535, out_ovf=0.
- Default params, in_bin=0 then 16'd9, back-to-back with in_valid and out_ready held high:
  - results 20'h00000 then 20'h00009;
  - out_valid pulses spaced exactly 17 cycles;
  - in_ready high on each handshake edge.
- DIGITS=4, in_bin=16'd12345 -> out_bcd=16'h2345, out_ovf=1. Then in_bin=16'd9999 -> 16'h9999, out_ovf=0.
- Backpressure, in_bin=16'd4095: out_ready low for 10 cycles after out_valid.
  - out_bcd stays 20'h04095, out_valid stays 1, in_ready stays 0.
  - out_ready high -> IDLE next edge.
- rst low for one edge at 5 cycles into a conversion of 16'd1234:
  - all outputs 0, state IDLE, in_ready=1;
  - no out_valid from the aborted value;
  - next conversion of 16'd77 gives 20'h00077.
- With BIN2BCD_SIGNED_EN: 16'h8000 -> out_neg=1, out_bcd=20'h32768; 16'hFFFF -> out_neg=1, 20'h00001; 16'h7FFF -> out_neg=0, 20'h32767.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encodings and the shift-add-3 digit adjust constants.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // A digit above this value is corrected before the next shift
    localparam logic [3:0] BCD_ADJ_THRESH = 4'd4;
    // Correction applied so the doubled digit carries into the next one
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bin2bcd_seq_adj.sv
// Single BCD digit correction for the shift-add-3 algorithm.
// A digit of 5..9 becomes 8..12, so the following left shift
// produces a decimal carry into the next digit. Never exceeds 4 bits.
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit > BCD_ADJ_THRESH) ? (i_digit + BCD_ADJ_ADD) : i_digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock).
// Valid/ready on input and output, sticky overflow when the value needs
// more than DIGITS decimal digits, back-to-back accept from DONE.
// Optional feature macro: BIN2BCD_SIGNED_EN (two's complement input,
// magnitude converted, sign reported on out_neg).
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      in_bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_ovf,
    output logic                  busy
`ifdef BIN2BCD_SIGNED_EN
    ,
    output logic                  out_neg
`endif
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int BCD_W = 4 * DIGITS;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [BIN_W-1:0]     r_bin;
    logic [BCD_W-1:0]     r_bcd;
    logic                 r_ovf;
    logic [CNT_W-1:0]     r_cnt;
    logic [BCD_W-1:0]     w_adj;
    logic [BIN_W-1:0]     w_mag;
    logic                 w_accept;

    // Magnitude loaded into the binary shift register at accept
`ifdef BIN2BCD_SIGNED_EN
    logic                 r_neg;
    logic                 w_neg_in;

    assign w_neg_in = in_bin[BIN_W-1];
    // Negation in BIN_W bits: the most negative value maps to 2^(BIN_W-1)
    assign w_mag    = w_neg_in ? (-in_bin) : in_bin;
    assign out_neg  = r_neg;
`else
    assign w_mag    = in_bin;
`endif

    // Per-digit add-3 correction applied ahead of every shift
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_digit (r_bcd[4*g +: 4]),
            .o_digit (w_adj[4*g +: 4])
        );
    end

    assign w_accept  = in_valid & in_ready;
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state == ST_SHIFT);
    assign out_bcd   = r_bcd;
    assign out_ovf   = r_ovf;

    // Next-state and combinational in_ready
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                in_ready = out_ready;
                if (out_ready) begin
                    w_state_nxt = in_valid ? ST_SHIFT : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register, bit counter and the {bcd, bin} shift register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_bcd   <= '0;
            r_ovf   <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
            r_neg   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_bin <= w_mag;
                r_bcd <= '0;
                r_ovf <= 1'b0;
                r_cnt <= CNT_W'(BIN_W);
`ifdef BIN2BCD_SIGNED_EN
                r_neg <= w_neg_in;
`endif
            end else if (r_state == ST_SHIFT) begin
                // Bit leaving the top digit means the value has outgrown DIGITS
                r_bcd <= {w_adj[BCD_W-2:0], r_bin[BIN_W-1]};
                r_bin <= {r_bin[BIN_W-2:0], 1'b0};
                r_ovf <= r_ovf | w_adj[BCD_W-1];
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: a 5-digit and a 4-digit instance,
// expected results computed with decimal arithmetic and queued at accept,
// popped and compared by per-instance monitors on each output handshake.
module tb_bin2bcd_seq;

    typedef struct {
        logic [19:0] bcd;
        logic        ovf;
        logic        neg;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0;
    logic [15:0] a_in_bin = '0;
    logic [19:0] a_out_bcd;
    logic        a_out_ovf, a_busy;
    logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1;
    logic [15:0] b_in_bin = '0;
    logic [15:0] b_out_bcd;
    logic        b_out_ovf, b_busy;
`ifdef BIN2BCD_SIGNED_EN
    logic        a_out_neg, b_out_neg;
`endif

    exp_t qa[$];
    exp_t qb[$];
    int   a_rise = 0, b_rise = 0;
    logic a_prev = 1'b0, b_prev = 1'b0;
    int   a_seen = 0;

    bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_bin(a_in_bin), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_bcd(a_out_bcd), .out_ovf(a_out_ovf), .busy(a_busy)
`ifdef BIN2BCD_SIGNED_EN
        , .out_neg(a_out_neg)
`endif
    );

    bin2bcd_seq #(.BIN_W(16), .DIGITS(4)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_bin(b_in_bin), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_bcd(b_out_bcd), .out_ovf(b_out_ovf), .busy(b_busy)
`ifdef BIN2BCD_SIGNED_EN
        , .out_neg(b_out_neg)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference: magnitude, decimal digits by div/mod, overflow by comparison
    function automatic exp_t model(input logic [15:0] v, input int digits, input int acc);
        exp_t   e;
        longint m;
        longint lim;
        e.neg = 1'b0;
        m     = longint'(v);
`ifdef BIN2BCD_SIGNED_EN
        if (v[15]) begin
            e.neg = 1'b1;
            m     = 65536 - m;
        end
`endif
        lim = 1;
        for (int i = 0; i < digits; i++) lim = lim * 10;
        e.ovf = (m >= lim);
        e.bcd = '0;
        for (int i = 0; i < digits; i++) begin
            e.bcd[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        e.acc = acc;
        return e;
    endfunction

    // Called just after a rising edge; returns just after the accept edge
    task automatic send_a(input logic [15:0] v);
        int n = 0;
        a_in_bin   = v;
        a_in_valid = 1'b1;
        @(negedge clk);
        while (!a_in_ready && n < 300) begin
            n++;
            @(negedge clk);
        end
        chk("a_accept_ready", 64'(a_in_ready), 64'd1);
        if (a_in_ready) qa.push_back(model(v, 5, cyc + 1));
        @(posedge clk);
        #1;
    endtask

    task automatic send_b(input logic [15:0] v);
        int n = 0;
        b_in_bin   = v;
        b_in_valid = 1'b1;
        @(negedge clk);
        while (!b_in_ready && n < 300) begin
            n++;
            @(negedge clk);
        end
        chk("b_accept_ready", 64'(b_in_ready), 64'd1);
        if (b_in_ready) qb.push_back(model(v, 4, cyc + 1));
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
    endtask

    // Monitor for the 5-digit instance
    always @(negedge clk) begin
        exp_t e;
        if (a_out_valid && !a_prev) begin
            a_rise = cyc;
            a_seen++;
        end
        a_prev = a_out_valid;
        if (a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL a_unexpected_output actual=%0h required=none", a_out_bcd);
            end else begin
                e = qa.pop_front();
                chk("a_bcd", 64'(a_out_bcd), 64'(e.bcd));
                chk("a_ovf", 64'(a_out_ovf), 64'(e.ovf));
                chk("a_latency", 64'(a_rise - e.acc), 64'd16);
`ifdef BIN2BCD_SIGNED_EN
                chk("a_neg", 64'(a_out_neg), 64'(e.neg));
`endif
            end
        end
    end

    // Monitor for the 4-digit instance
    always @(negedge clk) begin
        exp_t e;
        if (b_out_valid && !b_prev) b_rise = cyc;
        b_prev = b_out_valid;
        if (b_out_valid && b_out_ready) begin
            if (qb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL b_unexpected_output actual=%0h required=none", b_out_bcd);
            end else begin
                e = qb.pop_front();
                chk("b_bcd", 64'(b_out_bcd), 64'(e.bcd[15:0]));
                chk("b_ovf", 64'(b_out_ovf), 64'(e.ovf));
                chk("b_latency", 64'(b_rise - e.acc), 64'd16);
`ifdef BIN2BCD_SIGNED_EN
                chk("b_neg", 64'(b_out_neg), 64'(e.neg));
`endif
            end
        end
    end

    initial begin
        int          n;
        int          acc1;
        int          sent;
        logic        took;
        logic [15:0] v;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_out_bcd", 64'(a_out_bcd), 64'd0);
        chk("rst_out_ovf", 64'(a_out_ovf), 64'd0);
        chk("rst_busy", 64'(a_busy), 64'd0);
        chk("rst_in_ready", 64'(a_in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        a_out_ready = 1'b1;

        // Full-scale value
        send_a(16'hFFFF);
        a_in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        // Back-to-back: 0 then 9 with in_valid and out_ready held high
        send_a(16'd0);
        acc1 = cyc;
        send_a(16'd9);
        chk("b2b_accept_spacing", 64'(cyc - acc1), 64'd17);
        a_in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        // Backpressure on 4095
        a_out_ready = 1'b0;
        send_a(16'd4095);
        a_in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!a_out_valid && n < 100) begin
            n++;
            @(negedge clk);
        end
        for (int i = 0; i < 10; i++) begin
            chk("bp_bcd_hold", 64'(a_out_bcd), 64'h04095);
            chk("bp_valid_hold", 64'(a_out_valid), 64'd1);
            chk("bp_in_ready", 64'(a_in_ready), 64'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        a_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_idle_valid", 64'(a_out_valid), 64'd0);
        chk("bp_idle_busy", 64'(a_busy), 64'd0);
        chk("bp_idle_in_ready", 64'(a_in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Reset in the middle of a conversion of 1234
        send_a(16'd1234);
        a_in_valid = 1'b0;
        void'(qa.pop_back());
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_out_valid", 64'(a_out_valid), 64'd0);
        chk("abort_busy", 64'(a_busy), 64'd0);
        chk("abort_out_bcd", 64'(a_out_bcd), 64'd0);
        chk("abort_out_ovf", 64'(a_out_ovf), 64'd0);
        chk("abort_in_ready", 64'(a_in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        n = a_seen;
        repeat (30) @(posedge clk);
        #1;
        chk("abort_no_result", 64'(a_seen - n), 64'd0);
        send_a(16'd77);
        a_in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        // Four-digit instance: overflow and exact fit
        send_b(16'd12345);
        send_b(16'd9999);
        send_b(16'd10000);

`ifdef BIN2BCD_SIGNED_EN
        send_a(16'h8000);
        send_a(16'hFFFF);
        send_a(16'h7FFF);
        a_in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
`endif

        // Randomised traffic with random output backpressure
        sent = 0;
        n = 0;
        while (sent < 40 && n < 5000) begin
            n++;
            a_out_ready = ($urandom_range(0, 3) != 0);
            if (!a_in_valid && $urandom_range(0, 1) == 1) begin
                case ($urandom_range(0, 5))
                    0:       v = 16'h0000;
                    1:       v = 16'hFFFF;
                    2:       v = 16'h8000;
                    3:       v = 16'd99999 % 65536;
                    default: v = 16'($urandom);
                endcase
                a_in_bin   = v;
                a_in_valid = 1'b1;
            end
            @(negedge clk);
            took = a_in_valid && a_in_ready;
            if (took) begin
                qa.push_back(model(a_in_bin, 5, cyc + 1));
                sent++;
            end
            @(posedge clk);
            #1;
            if (took) a_in_valid = 1'b0;
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;

        // Drain
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 2000) begin
            n++;
            @(posedge clk);
        end
        chk("drain_qa_empty", 64'(qa.size()), 64'd0);
        chk("drain_qb_empty", 64'(qb.size()), 64'd0);
        chk("random_sent", 64'(sent), 64'd40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
